hdlc_tx_sequencer: RTL and testbench
====================================

// Module: hdlc_tx_sequencer
// PURPOSE
//  Sequences HDLC transmission: fetches frame bytes from the Tx buffer and emits one bit per Clk on Tx.
//  Emits start flag, LSB-first data with zero insertion, end flag, idle ones, and the abort pattern.
//  Sits between the Tx buffer/register interface and the serial Tx line.
//  Drives Tx, Tx_ValidFrame and Tx_AbortedTrans as checked by the HDLC assertion module.
// PARAMETERS
//  MAX_BYTES  126  largest accepted Tx_FrameSize (buffer depth)
// PORTS
//  Clk              in   1  system clock, one serial bit per rising edge
//  Rst              in   1  reset; one clock, reset is asynchronous and active-high
//  Tx_Enable        in   1  start request, sampled only in IDLE
//  Tx_FrameSize     in   8  byte count, sampled with Tx_Enable; valid range 1..MAX_BYTES
//  Tx_Data          in   8  buffer read data, valid the cycle after Tx_RdBuff
//  Tx_AbortFrame    in   1  abort request, level, sampled each cycle
//  Tx_RdBuff        out  1  one-cycle buffer read strobe
//  Tx               out  1  registered serial output
//  Tx_ValidFrame    out  1  high while start flag and data are being emitted
//  Tx_AbortedTrans  out  1  sticky abort status
//  Tx_Done          out  1  one-cycle pulse after the last end-flag bit
//  Tx_Busy          out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; Tx=1; all other outputs 0; counters and holding register cleared.
//  Reset mid-frame: immediate return to IDLE, Tx=1. No Done and no abort pattern are emitted.
//  States: IDLE -> START_FLAG -> DATA -> END_FLAG -> IDLE. ABORT is entered from START_FLAG or DATA.
//  IDLE: Tx=1. Tx_Enable=1 with size in 1..MAX_BYTES -> START_FLAG. Same cycle: pulse Tx_RdBuff, clear Tx_AbortedTrans.
//   Size 0 or >MAX_BYTES: request ignored; no strobe, state stays IDLE. Tx_Enable outside IDLE: ignored.
//  Latency: Tx_Enable accepted at edge n -> first flag bit on Tx after edge n+1.
//  START_FLAG: 8 cycles of 0,1,1,1,1,1,1,0 (0x7E, LSB first). Tx_ValidFrame=1.
//   The prefetched byte is loaded into the shift register at the end of this state.
//  DATA: one bit per cycle, LSB first. Tx_ValidFrame=1.
//   Pulse Tx_RdBuff when a byte is loaded into the shift register and bytes remain.
//   Holding register captures Tx_Data on the next cycle.
//   Byte counter decrements on each load; it is 8 bits wide and never wraps below 0.
//  Zero insertion: ones counter (3 bits) counts consecutive 1s emitted in DATA.
//   After the 5th 1, the next cycle emits an inserted 0 and the shift register stalls; counter then clears.
//   Counter clears on every emitted 0 and on entry to DATA. Flag bits never count.
//   Count carries across byte boundaries.
//   If the last data bit completes five 1s, the stuffed 0 is emitted before END_FLAG.
//  END_FLAG: 0x7E, 8 cycles, Tx_ValidFrame=0. Tx_Done pulses on the cycle after the last flag bit, state IDLE.
//  Abort: Tx_AbortFrame=1 in START_FLAG or DATA -> ABORT on the next edge.
//   The pending stuff bit is dropped. Tx_ValidFrame=0 and Tx_AbortedTrans=1 from that edge.
//   ABORT emits 0,1,1,1,1,1,1,1 (0xFE LSB first) over 8 cycles, then IDLE.
//   Tx_AbortedTrans holds until the next accepted Tx_Enable. No Tx_Done after an abort.
//   Tx_AbortFrame in IDLE, END_FLAG or ABORT: ignored.
//  Simultaneous Tx_AbortFrame and final data bit: abort wins.
// TESTING
//  1. Size 1, byte 0x00 -> Tx = 01111110 00000000 01111110 then 1s; one Tx_RdBuff; ValidFrame high 16 cycles; one Done.
//  2. Size 1, byte 0xFF -> data bits 11111 0 111 (9 cycles); no stray stuff bit; end flag follows.
//  3. Size 2, bytes 0xF8,0x03 -> data 00011111 0 11000000 (stuff spans byte boundary); 2 strobes.
//  4. Size 10, Tx_AbortFrame at 3rd data byte -> next 8 bits 01111111, then 1s; AbortedTrans=1; no Done.
//     Next valid Tx_Enable clears AbortedTrans.
//  5. Tx_Enable with size 0, then size 127, then mid-frame -> all ignored; no strobes; frame unaffected.
//  6. Rst asserted mid-DATA -> Tx=1 and all other outputs 0 without waiting for Clk; fresh frame after release is correct.

Source files
------------

// File: rtl/hdlc_tx_sequencer_if.sv
// Bundle of the Tx buffer / register side and serial line signals of the
// HDLC transmit sequencer. The master side drives the request and buffer
// data; the slave side (the sequencer) drives the strobe, line and status.
interface hdlc_tx_sequencer_if;
  logic       Tx_Enable;
  logic [7:0] Tx_FrameSize;
  logic [7:0] Tx_Data;
  logic       Tx_AbortFrame;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Done;
  logic       Tx_Busy;
  logic [2:0] dbg_state;

  modport master (
    output Tx_Enable, Tx_FrameSize, Tx_Data, Tx_AbortFrame,
    input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done, Tx_Busy,
    input  dbg_state
  );

  modport slave (
    input  Tx_Enable, Tx_FrameSize, Tx_Data, Tx_AbortFrame,
    output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done, Tx_Busy,
    output dbg_state
  );
endinterface

// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit sequencer: emits start flag, LSB-first data with zero
// insertion, end flag, idle ones and the abort pattern, one bit per clock.
// All line and status outputs are registered; Tx lags the state by one clock.
//
// Buffer read handshake: Tx_RdBuff is a one-cycle strobe with no back
// pressure. The buffer must present the byte on Tx_Data during the cycle
// after the strobe; the holding register captures it at the end of that cycle.
module hdlc_tx_sequencer #(
  parameter int MAX_BYTES = 126
) (
  input  logic               Clk,
  input  logic               Rst,
  hdlc_tx_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_END   = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  localparam logic [7:0] FLAG_PAT  = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'hFE;
  localparam logic [7:0] MAX_SIZE  = 8'(MAX_BYTES);

  logic [2:0] state_q, state_d;
  logic [2:0] bit_q, bit_d;         // flag/abort bit index, or data bit index
  logic [2:0] ones_q, ones_d;       // consecutive data ones emitted
  logic [7:0] bytes_q, bytes_d;     // bytes still to be loaded into shift_q
  logic [7:0] hold_q, hold_d;       // prefetched next byte
  logic [7:0] shift_q, shift_d;     // byte currently being serialised
  logic       last_q, last_d;       // data finished, only a stuff bit remains
  logic       rd_q, rd_d;
  logic       rd_dly_q, rd_dly_d;   // strobe delayed to the data-valid cycle
  logic       tx_q, tx_d;
  logic       valid_q, valid_d;
  logic       aborted_q, aborted_d;
  logic       done_pend_q, done_pend_d;
  logic       done_q, done_d;

  logic       size_ok;
  logic       abort_req;

  assign size_ok   = (bus.Tx_FrameSize != 8'd0) && (bus.Tx_FrameSize <= MAX_SIZE);
  assign abort_req = bus.Tx_AbortFrame && ((state_q == S_START) || (state_q == S_DATA));

  // Next-state, next-bit and status computation for every state.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    ones_d      = ones_q;
    bytes_d     = bytes_q;
    shift_d     = shift_q;
    last_d      = last_q;
    aborted_d   = aborted_q;
    hold_d      = rd_dly_q ? bus.Tx_Data : hold_q;
    rd_dly_d    = rd_q;
    rd_d        = 1'b0;
    tx_d        = 1'b1;
    valid_d     = 1'b0;
    done_pend_d = 1'b0;
    done_d      = done_pend_q;

    if (abort_req) begin
      // Abort replaces whatever this state would emit, including a pending
      // stuff bit; the first abort bit goes out on this very edge.
      state_d   = S_ABORT;
      bit_d     = 3'd1;
      tx_d      = ABORT_PAT[0];
      ones_d    = 3'd0;
      last_d    = 1'b0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.Tx_Enable && size_ok) begin
            state_d   = S_START;
            bit_d     = 3'd0;
            bytes_d   = bus.Tx_FrameSize;
            rd_d      = 1'b1;
            aborted_d = 1'b0;
          end
        end

        S_START: begin
          tx_d    = FLAG_PAT[bit_q];
          valid_d = 1'b1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_DATA;
            shift_d = hold_q;
            ones_d  = 3'd0;
            last_d  = 1'b0;
            if (bytes_q != 8'd0) begin
              bytes_d = bytes_q - 8'd1;
            end
            rd_d = (bytes_q > 8'd1);
          end
        end

        S_DATA: begin
          valid_d = 1'b1;
          if (ones_q == 3'd5) begin
            // Inserted zero: the shift register and bit index stall.
            tx_d   = 1'b0;
            ones_d = 3'd0;
            if (last_q) begin
              state_d = S_END;
              bit_d   = 3'd0;
              last_d  = 1'b0;
            end
          end else begin
            tx_d    = shift_q[0];
            ones_d  = shift_q[0] ? (ones_q + 3'd1) : 3'd0;
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (bytes_q != 8'd0) begin
                shift_d = hold_q;
                bytes_d = bytes_q - 8'd1;
                rd_d    = (bytes_q > 8'd1);
              end else if (shift_q[0] && (ones_q == 3'd4)) begin
                last_d = 1'b1;
              end else begin
                state_d = S_END;
                bit_d   = 3'd0;
              end
            end
          end
        end

        S_END: begin
          tx_d  = FLAG_PAT[bit_q];
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d     = S_IDLE;
            done_pend_d = 1'b1;
          end
        end

        S_ABORT: begin
          tx_d  = ABORT_PAT[bit_q];
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs; reset forces the idle line.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      bit_q       <= 3'd0;
      ones_q      <= 3'd0;
      bytes_q     <= 8'd0;
      hold_q      <= 8'd0;
      shift_q     <= 8'd0;
      last_q      <= 1'b0;
      rd_q        <= 1'b0;
      rd_dly_q    <= 1'b0;
      tx_q        <= 1'b1;
      valid_q     <= 1'b0;
      aborted_q   <= 1'b0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      ones_q      <= ones_d;
      bytes_q     <= bytes_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      rd_q        <= rd_d;
      rd_dly_q    <= rd_dly_d;
      tx_q        <= tx_d;
      valid_q     <= valid_d;
      aborted_q   <= aborted_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
    end
  end

  assign bus.Tx_RdBuff       = rd_q;
  assign bus.Tx              = tx_q;
  assign bus.Tx_ValidFrame   = valid_q;
  assign bus.Tx_AbortedTrans = aborted_q;
  assign bus.Tx_Done         = done_q;
  assign bus.Tx_Busy         = (state_q != S_IDLE);
  assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Bench for hdlc_tx_sequencer: directed and random frames compared bit by
// bit against a bit-stream model built from the HDLC framing rules.
module tb_hdlc_tx_sequencer;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  hdlc_tx_sequencer_if bus ();

  hdlc_tx_sequencer #(.MAX_BYTES(126)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Clock / reset block
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fails  = 0;
  int strobes  = 0;
  int rd_idx   = 0;

  logic [7:0] mem [0:15];
  logic       exp_q[$];   // expected Tx bit per line position
  logic       vld_q[$];   // expected Tx_ValidFrame per line position
  int         ld_q[$];    // line position at which byte j is loaded

  task automatic chk1(input string tag, input int idx, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s[%0d]: observed %0b, expected %0b", tag, idx, obs, expv);
    end
  endtask

  task automatic chki(input string tag, input int idx, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s[%0d]: observed %0d, expected %0d", tag, idx, obs, expv);
    end
  endtask

  // Buffer model: answers each strobe with the next byte one cycle later.
  initial begin
    bus.Tx_Data = 8'h00;
    forever begin
      @(negedge Clk);
      if (bus.Tx_RdBuff === 1'b1) begin
        strobes++;
        @(posedge Clk);
        #1;
        bus.Tx_Data = mem[rd_idx % 16];
        rd_idx++;
      end
    end
  end

  // Reference model: the full line stream of one frame as a bit list.
  task automatic build_model(input int n, input int abort_pos, output int len, output int data_end);
    logic [7:0] flag;
    logic       bt;
    int         ones;
    flag = 8'h7E;
    exp_q.delete();
    vld_q.delete();
    ld_q.delete();
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back(flag[b]);
      vld_q.push_back(1'b1);
    end
    ld_q.push_back(8);
    ones = 0;
    for (int j = 0; j < n; j++) begin
      for (int b = 0; b < 8; b++) begin
        bt = mem[j][b];
        exp_q.push_back(bt);
        vld_q.push_back(1'b1);
        if (b == 7) ld_q.push_back(exp_q.size());
        ones = bt ? ones + 1 : 0;
        if (ones == 5) begin
          exp_q.push_back(1'b0);
          vld_q.push_back(1'b1);
          ones = 0;
        end
      end
    end
    data_end = exp_q.size();
    if (abort_pos >= 0) begin
      while (exp_q.size() > abort_pos) begin
        void'(exp_q.pop_back());
        void'(vld_q.pop_back());
      end
      exp_q.push_back(1'b0);
      vld_q.push_back(1'b0);
      repeat (7) begin
        exp_q.push_back(1'b1);
        vld_q.push_back(1'b0);
      end
    end else begin
      for (int b = 0; b < 8; b++) begin
        exp_q.push_back(flag[b]);
        vld_q.push_back(1'b0);
      end
    end
    len = exp_q.size();
  endtask

  // Driver: one frame from request to idle, checked every cycle.
  task automatic run_frame(input int n, input int abort_pos, input int mid_en_at, input int rst_at);
    int len, dend, s0, exp_strb;
    build_model(n, abort_pos, len, dend);
    exp_strb = n;
    if (abort_pos >= 0) begin
      exp_strb = 1;
      for (int j = 0; j < n - 1; j++) if (ld_q[j] <= abort_pos) exp_strb++;
    end
    repeat (2) @(posedge Clk);
    #1;
    rd_idx = 0;
    s0 = strobes;
    bus.Tx_FrameSize = 8'(n);
    bus.Tx_Enable = 1'b1;
    @(posedge Clk);
    #1 bus.Tx_Enable = 1'b0;
    for (int i = 0; i <= len + 3; i++) begin
      @(negedge Clk);
      chk1("tx", i, bus.Tx, (i >= 1 && i <= len) ? exp_q[i-1] : 1'b1);
      chk1("valid", i, bus.Tx_ValidFrame, (i >= 1 && i <= len) ? vld_q[i-1] : 1'b0);
      chk1("busy", i, bus.Tx_Busy, i < len);
      chk1("done", i, bus.Tx_Done, (abort_pos < 0) && (i == len + 1));
      chk1("aborted", i, bus.Tx_AbortedTrans, (abort_pos >= 0) && (i > abort_pos));
      if (i == 0) chk1("rd_first", i, bus.Tx_RdBuff, 1'b1);
      if (i == abort_pos) bus.Tx_AbortFrame = 1'b1;
      if (i == abort_pos + 3) bus.Tx_AbortFrame = 1'b0;
      if (i == mid_en_at) begin
        bus.Tx_Enable = 1'b1;
        bus.Tx_FrameSize = 8'd3;
      end
      if (i == mid_en_at + 2) bus.Tx_Enable = 1'b0;
      if (i == rst_at) begin
        #1 Rst = 1'b1;
        #1;
        chk1("rst_tx", i, bus.Tx, 1'b1);
        chk1("rst_valid", i, bus.Tx_ValidFrame, 1'b0);
        chk1("rst_busy", i, bus.Tx_Busy, 1'b0);
        chk1("rst_rd", i, bus.Tx_RdBuff, 1'b0);
        chk1("rst_done", i, bus.Tx_Done, 1'b0);
        chk1("rst_aborted", i, bus.Tx_AbortedTrans, 1'b0);
        #1 Rst = 1'b0;
        break;
      end
    end
    #1;
    if (rst_at < 0) chki("strobes", n, strobes - s0, exp_strb);
  endtask

  // Driver: a request that must be ignored while idle.
  task automatic try_bad(input int size);
    int s0;
    @(posedge Clk);
    #1;
    s0 = strobes;
    bus.Tx_FrameSize = 8'(size);
    bus.Tx_Enable = 1'b1;
    @(posedge Clk);
    #1 bus.Tx_Enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk1("bad_tx", size, bus.Tx, 1'b1);
      chk1("bad_busy", size, bus.Tx_Busy, 1'b0);
    end
    chki("bad_strobes", size, strobes - s0, 0);
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // Directed and random steps
  initial begin
    int len, dend, p, n;
    bus.Tx_Enable = 1'b0;
    bus.Tx_FrameSize = 8'd0;
    bus.Tx_AbortFrame = 1'b0;
    #1 Rst = 1'b1;
    #1;
    chk1("reset_tx", 0, bus.Tx, 1'b1);
    chk1("reset_valid", 0, bus.Tx_ValidFrame, 1'b0);
    chk1("reset_busy", 0, bus.Tx_Busy, 1'b0);
    chk1("reset_rd", 0, bus.Tx_RdBuff, 1'b0);
    chk1("reset_done", 0, bus.Tx_Done, 1'b0);
    chk1("reset_aborted", 0, bus.Tx_AbortedTrans, 1'b0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;

    // Single zero byte
    mem[0] = 8'h00;
    run_frame(1, -1, -1, -1);
    // All ones: one stuff bit inside the byte
    mem[0] = 8'hFF;
    run_frame(1, -1, -1, -1);
    // Last data bit completes five ones: stuff bit before end flag
    mem[0] = 8'hF8;
    run_frame(1, -1, -1, -1);
    // Stuffing across a byte boundary
    mem[0] = 8'hF8;
    mem[1] = 8'h03;
    run_frame(2, -1, -1, -1);

    // Abort inside the third data byte
    for (int j = 0; j < 10; j++) mem[j] = 8'($urandom);
    build_model(10, -1, len, dend);
    p = ld_q[2] + 3;
    run_frame(10, p, -1, -1);
    // Status sticks in idle; abort request in idle is ignored
    bus.Tx_AbortFrame = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk1("idle_aborted", i, bus.Tx_AbortedTrans, 1'b1);
      chk1("idle_abort_tx", i, bus.Tx, 1'b1);
      chk1("idle_abort_busy", i, bus.Tx_Busy, 1'b0);
    end
    bus.Tx_AbortFrame = 1'b0;

    // Ignored requests: out-of-range sizes, then one issued mid-frame
    try_bad(0);
    try_bad(127);
    for (int j = 0; j < 6; j++) mem[j] = 8'($urandom);
    run_frame(6, -1, 20, -1);

    // Reset in the middle of data, then a clean frame
    for (int j = 0; j < 4; j++) mem[j] = 8'hFF;
    run_frame(4, -1, -1, 20);
    for (int j = 0; j < 3; j++) mem[j] = 8'($urandom);
    run_frame(3, -1, -1, -1);

    // Random frames, every other one aborted at a random point
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 12);
      for (int j = 0; j < n; j++) mem[j] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if (k % 2 == 1) begin
        build_model(n, -1, len, dend);
        p = $urandom_range(0, dend - 1);
        run_frame(n, p, -1, -1);
      end else begin
        run_frame(n, -1, -1, -1);
      end
    end

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
